alu_seq_112: RTL and testbench
==============================

// Module: alu_seq_112
// PURPOSE
// - Double-width (2*WITDH) arithmetic/logic sequencer sitting directly upstream of alu_112 and consuming its result/co.
// - Accepts one 2*WITDH-bit operation per valid/ready handshake.
// - Executes it as two passes through one WITDH-bit alu_112: low word first, then high word, chaining co through a carry/borrow register.
// - Returns the 2*WITDH-bit result and final co on a valid/ready output handshake.
// PARAMETERS
// - WITDH  32  ALU word width; operands/result are 2*WITDH bits.
// PORTS
// - clk         in   1        single clock; all state updates on rising edge.
// - rst         in   1        synchronous, active-high reset.
// - in_valid    in   1        request valid.
// - in_ready    out  1        block can accept a request.
// - in_op       in   3        op code, same encoding as alu_112.
// - in_a        in   2*WITDH  operand A.
// - in_b        in   2*WITDH  operand B.
// - in_ci       in   1        carry/borrow in (ops 001/010 only).
// - out_valid   out  1        result valid.
// - out_ready   in   1        consumer accepts result.
// - out_result  out  2*WITDH  result.
// - out_co      out  1        final carry (add) / borrow (sub); 0 for logic ops.
// BEHAVIOUR
// - Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
// - Reset: state=IDLE; out_valid=0, out_result=0, out_co=0; carry reg=0; in_ready=1 from the first cycle after reset.
// - Reset mid-operation: any in-flight or undelivered transaction is dropped and no result is produced.
// - Op codes:
//   - 000 A+B
//   - 001 A+B+ci
//   - 010 A-B-ci (co=1 means borrow)
//   - 011 AND
//   - 100 OR
//   - 101 XOR
//   - 110 ~A
//   - 111 reserved: result=0, co=0, same latency.
// - FSM states: IDLE -> LO -> HI -> DONE -> IDLE.
// - IDLE:
//   - in_ready=1.
//   - On in_valid: latch in_op, in_a, in_b, in_ci; go to LO.
// - LO:
//   - Drive ALU with A[WITDH-1:0] and B[WITDH-1:0].
//   - ALU op: 000 -> 000 with ci=0; 001 -> 001 with ci=in_ci; 010 -> 010 with ci=in_ci; logic ops unchanged.
//   - Latch ALU result into result[WITDH-1:0] and ALU co into the carry reg; go to HI.
// - HI:
//   - Drive the upper halves of A and B.
//   - ALU op: 000/001 -> 001 with ci=carry reg; 010 -> 010 with ci=carry reg; logic ops unchanged.
//   - Latch result[2W-1:W]; out_co = ALU co for arithmetic ops, 0 otherwise.
//   - Go to DONE.
// - DONE:
//   - out_valid=1; out_result and out_co are stable.
//   - On out_ready: out_valid=0 next cycle; go to IDLE.
// - Handshakes:
//   - in_ready=1 only in IDLE; no overlap between requests.
//   - Latency: out_valid rises 2 cycles after the accepting edge.
//   - Minimum 4 cycles per transaction.
//   - out_ready held low: stay in DONE indefinitely; outputs stable; in_ready stays 0.
//   - in_valid while busy: ignored and not captured.
//   - out_ready while not out_valid: no effect.
// - Arithmetic: unsigned modulo 2^(2*WITDH); the carry chain is the only cross-word dependency.
// STRUCTURE
// - Shared include alu_112_defs.vh: op-code constants (ALU_ADD, ALU_ADDC, ALU_SUBC, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT) and FSM state encodings.
// - Sub-module: one alu_112 #(.WITDH(WITDH)), combinational, muxed by state; no other sub-modules.
// TESTING
// - ADD, A=64'h0000_0000_FFFF_FFFF, B=1 -> out_result=64'h0000_0001_0000_0000, co=0; out_valid exactly 2 cycles after accept.
// - ADD, A=64'hFFFF_FFFF_FFFF_FFFF, B=1 -> out_result=0, co=1.
// - SUBC, A=245, B=678, ci=1 -> out_result=2^64-434 (64'hFFFF_FFFF_FFFF_FE4E), co=1; then A=456, B=234, ci=1 -> 221, co=0.
// - XOR, A=64'hF0F0_0000_0000_00FF, B=64'hFFFF_0000_0000_000F -> 64'h0F0F_0000_0000_00F0, co=0; op 111 -> 0, co=0.
// - Backpressure: out_ready=0 for 5 cycles -> out_valid and result held, in_ready=0, new in_valid ignored; accept on 6th cycle.
// - Reset asserted in state HI -> next cycle out_valid=0, out_result=0, in_ready=1; the dropped result never appears.

Source files
------------

// File: rtl/alu_seq_112_pkg.sv
// Shared op codes, FSM encodings and helpers for the
// double-width ALU sequencer and its single-word ALU.
package alu_seq_112_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_ADDC = 3'b001;
  localparam logic [2:0] ALU_SUBC = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_XOR  = 3'b101;
  localparam logic [2:0] ALU_NOT  = 3'b110;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_ADDC) ||
           (op == ALU_SUBC);
  endfunction

endpackage

// File: rtl/alu_seq_112_alu.sv
// Single-word combinational ALU (alu_112).
// co is carry for adds, borrow for subtract, 0 otherwise.
module alu_112
  import alu_seq_112_pkg::*;
#(
  parameter int WITDH = 32
) (
  input  logic [2:0]       op,
  input  logic [WITDH-1:0] a,
  input  logic [WITDH-1:0] b,
  input  logic             ci,
  output logic [WITDH-1:0] result,
  output logic             co
);

  logic [WITDH:0] cin;
  logic [WITDH:0] sum;
  logic [WITDH:0] diff;

  // plain ADD never consumes ci
  assign cin  = {{WITDH{1'b0}}, (op == ALU_ADD) ? 1'b0 : ci};
  assign sum  = {1'b0, a} + {1'b0, b} + cin;
  assign diff = {1'b0, a} - {1'b0, b} - cin;

  always_comb begin
    result = '0;
    co     = 1'b0;
    case (op)
      ALU_ADD, ALU_ADDC: begin
        result = sum[WITDH-1:0];
        co     = sum[WITDH];
      end
      ALU_SUBC: begin
        result = diff[WITDH-1:0];
        co     = diff[WITDH];
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOT: result = ~a;
      default: begin
        result = '0;
        co     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq_112.sv
// Double-width ALU sequencer: runs one 2*WITDH op as
// low then high pass through a single alu_112.
module alu_seq_112
  import alu_seq_112_pkg::*;
#(
  parameter int WITDH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic [2*WITDH-1:0] in_a,
  input  logic [2*WITDH-1:0] in_b,
  input  logic               in_ci,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WITDH-1:0] out_result,
  output logic               out_co
);

  logic [1:0]         state;
  logic [2:0]         op_q;
  logic [2*WITDH-1:0] a_q;
  logic [2*WITDH-1:0] b_q;
  logic               ci_q;
  logic               carry_q;
  logic [2*WITDH-1:0] result_q;
  logic               co_q;

  logic [2:0]         alu_op;
  logic [WITDH-1:0]   alu_a;
  logic [WITDH-1:0]   alu_b;
  logic               alu_ci;
  logic [WITDH-1:0]   alu_result;
  logic               alu_co;

  assign in_ready   = (state == S_IDLE);
  assign out_valid  = (state == S_DONE);
  assign out_result = result_q;
  assign out_co     = co_q;

  // high pass turns ADD into ADDC so the low-word carry chains in
  always_comb begin
    alu_a  = a_q[WITDH-1:0];
    alu_b  = b_q[WITDH-1:0];
    alu_op = op_q;
    alu_ci = 1'b0;
    if (state == S_HI) begin
      alu_a = a_q[2*WITDH-1:WITDH];
      alu_b = b_q[2*WITDH-1:WITDH];
      if (op_q == ALU_ADD || op_q == ALU_ADDC) begin
        alu_op = ALU_ADDC;
        alu_ci = carry_q;
      end else if (op_q == ALU_SUBC) begin
        alu_ci = carry_q;
      end
    end else if (op_q == ALU_ADDC || op_q == ALU_SUBC) begin
      alu_ci = ci_q;
    end
  end

  alu_112 #(.WITDH(WITDH)) u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .ci     (alu_ci),
    .result (alu_result),
    .co     (alu_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ci_q     <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      co_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q  <= in_op;
            a_q   <= in_a;
            b_q   <= in_b;
            ci_q  <= in_ci;
            state <= S_LO;
          end
        end
        S_LO: begin
          result_q[WITDH-1:0] <= alu_result;
          carry_q             <= alu_co;
          state               <= S_HI;
        end
        S_HI: begin
          result_q[2*WITDH-1:WITDH] <= alu_result;
          co_q  <= is_arith(op_q) & alu_co;
          state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_112.sv
// Directed self-checking bench for alu_seq_112.
// Inputs driven 1ns after rising edges, outputs sampled there too.
module tb_alu_seq_112;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDC = 3'b001;
  localparam logic [2:0] OP_SUBC = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_RSV  = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic        in_ci = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;
  logic        out_co;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_seq_112 #(.WITDH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_ci      (in_ci),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_co     (out_co)
  );

  task automatic send(input logic [2:0] op,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic ci);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b1;
    in_op = op; in_a = a; in_b = b; in_ci = ci;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // rising edges from the accepting edge until out_valid is seen
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!out_valid && n < 20);
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // drive one transaction, capture its outputs, then consume it
  task automatic run_op(input logic [2:0] op,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic ci, output int lat,
                        output logic [63:0] res, output logic co);
    send(op, a, b, ci);
    wait_valid(lat);
    res = out_result;
    co = out_co;
    pop();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (out_result !== 64'd0) begin
      failures++;
      $display("FAIL reset_out_result got=%h exp=0", out_result);
    end
    checks++;
    if (out_co !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_co got=%b exp=0", out_co);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_add();
    int lat;
    logic [63:0] res;
    logic co;
    logic [63:0] ea [4];
    logic [63:0] eb [4];
    logic [2:0]  eop [4];
    logic        eci [4];
    logic [63:0] er [4];
    logic        ec [4];
    ea[0] = 64'h0000_0000_FFFF_FFFF; eb[0] = 64'd1;
    eop[0] = OP_ADD;  eci[0] = 1'b0;
    er[0] = 64'h0000_0001_0000_0000; ec[0] = 1'b0;
    ea[1] = 64'hFFFF_FFFF_FFFF_FFFF; eb[1] = 64'd1;
    eop[1] = OP_ADD;  eci[1] = 1'b0;
    er[1] = 64'd0; ec[1] = 1'b1;
    ea[2] = 64'd1; eb[2] = 64'd1;
    eop[2] = OP_ADD;  eci[2] = 1'b1;
    er[2] = 64'd2; ec[2] = 1'b0;
    ea[3] = 64'h0000_0000_FFFF_FFFF; eb[3] = 64'd0;
    eop[3] = OP_ADDC; eci[3] = 1'b1;
    er[3] = 64'h0000_0001_0000_0000; ec[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_op(eop[i], ea[i], eb[i], eci[i], lat, res, co);
      checks++;
      if (lat !== 2) begin
        failures++;
        $display("FAIL add%0d_latency got=%0d exp=2", i, lat);
      end
      checks++;
      if (res !== er[i]) begin
        failures++;
        $display("FAIL add%0d_result got=%h exp=%h", i, res, er[i]);
      end
      checks++;
      if (co !== ec[i]) begin
        failures++;
        $display("FAIL add%0d_co got=%b exp=%b", i, co, ec[i]);
      end
    end
  endtask

  task automatic test_subc_back_to_back();
    int lat;
    logic [63:0] res;
    logic co;
    run_op(OP_SUBC, 64'd245, 64'd678, 1'b1, lat, res, co);
    checks++;
    if (res !== 64'hFFFF_FFFF_FFFF_FE4E) begin
      failures++;
      $display("FAIL sub0_result got=%h exp=fffffffffffffe4e", res);
    end
    checks++;
    if (co !== 1'b1) begin
      failures++;
      $display("FAIL sub0_borrow got=%b exp=1", co);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL sub0_ready_after got=%b exp=1", in_ready);
    end
    run_op(OP_SUBC, 64'd456, 64'd234, 1'b1, lat, res, co);
    checks++;
    if (res !== 64'd221) begin
      failures++;
      $display("FAIL sub1_result got=%0d exp=221", res);
    end
    checks++;
    if (co !== 1'b0) begin
      failures++;
      $display("FAIL sub1_borrow got=%b exp=0", co);
    end
    run_op(OP_SUBC, 64'h0000_0001_0000_0000, 64'd1, 1'b0,
           lat, res, co);
    checks++;
    if (res !== 64'h0000_0000_FFFF_FFFF || co !== 1'b0) begin
      failures++;
      $display("FAIL sub2_xword got=%h/%b exp=00000000ffffffff/0",
               res, co);
    end
  endtask

  task automatic test_logic();
    int lat;
    logic [63:0] res;
    logic co;
    logic [2:0]  lop [5];
    logic [63:0] la [5];
    logic [63:0] lb [5];
    logic [63:0] lr [5];
    lop[0] = OP_XOR;
    la[0] = 64'hF0F0_0000_0000_00FF; lb[0] = 64'hFFFF_0000_0000_000F;
    lr[0] = 64'h0F0F_0000_0000_00F0;
    lop[1] = OP_RSV;
    la[1] = 64'hFFFF_FFFF_FFFF_FFFF; lb[1] = 64'd1;
    lr[1] = 64'd0;
    lop[2] = OP_AND;
    la[2] = 64'hF0F0_0000_0000_00FF; lb[2] = 64'hFFFF_0000_0000_000F;
    lr[2] = 64'hF0F0_0000_0000_000F;
    lop[3] = OP_OR;
    la[3] = 64'h1234_0000_0000_0000; lb[3] = 64'h0000_0000_0000_5678;
    lr[3] = 64'h1234_0000_0000_5678;
    lop[4] = OP_NOT;
    la[4] = 64'h0000_FFFF_0000_0001; lb[4] = 64'hFFFF_FFFF_FFFF_FFFF;
    lr[4] = 64'hFFFF_0000_FFFF_FFFE;
    for (int i = 0; i < 5; i++) begin
      run_op(lop[i], la[i], lb[i], 1'b1, lat, res, co);
      checks++;
      if (res !== lr[i]) begin
        failures++;
        $display("FAIL logic%0d_result got=%h exp=%h", i, res, lr[i]);
      end
      checks++;
      if (co !== 1'b0 || lat !== 2) begin
        failures++;
        $display("FAIL logic%0d_co_lat got=%b/%0d exp=0/2",
                 i, co, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    send(OP_ADD, 64'h0000_0002_8000_0000, 64'h0000_0003_8000_0000,
         1'b0);
    wait_valid(lat);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_op = OP_AND; in_a = '1; in_b = '1; in_ci = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          out_result !== 64'h0000_0006_0000_0000 || out_co !== 1'b0)
      begin
        failures++;
        $display("FAIL bp_hold%0d got v=%b r=%b res=%h co=%b exp 1/0/0000000600000000/0",
                 i, out_valid, in_ready, out_result, out_co);
      end
    end
    in_valid = 1'b0;
    pop();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release got v=%b r=%b exp 0/1",
               out_valid, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL bp_ignored_req got=%0d valid cycles exp=0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    send(OP_ADD, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
         1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 64'd0 ||
        in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid got v=%b res=%h r=%b exp 0/0/1",
               out_valid, out_result, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    out_ready = 1'b0;
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL rst_mid_dropped got=%0d valid cycles exp=0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_subc_back_to_back();
    test_logic();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
